// File: rtl/bist_misr.sv
// Multiple-input signature register for BIST response compaction.
// Frames a session with running/bist_end and registers a pass/fail verdict against golden values.
module bist_misr #(
    parameter int unsigned     WIDTH  = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h002D,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001,
    parameter logic [WIDTH-1:0] GOLDEN = 16'h0000,
    parameter int unsigned     CW     = 16,
    parameter logic [CW-1:0]   NVEC   = 16'd1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             running,
    input  logic             bist_end,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_in,
    output logic [WIDTH-1:0] signature,
    output logic [CW-1:0]    vec_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {StIdle, StCompact, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                pass_d = 1'b0;
                if (running) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = StCompact;
                end
            end
            StCompact: begin
                // bist_end wins over both abort and a same-cycle response word
                if (bist_end) begin
                    pass_d  = (sig_q == GOLDEN) && (cnt_q == NVEC);
                    state_d = StDone;
                end else if (!running) begin
                    pass_d  = 1'b0;
                    state_d = StIdle;
                end else if (resp_valid) begin
                    sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp_in;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (!bist_end) begin
                    pass_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                pass_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StCompact);
        done_d = (state_d == StDone);
    end

    assign signature = sig_q;
    assign vec_cnt   = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_bist_misr.sv
// Self-checking bench for bist_misr: a behavioural model pushes expected outputs per cycle,
// each test pops them against captured DUT outputs, plus spot checks against hand-derived values.
module tb_bist_misr;

    localparam int unsigned    WIDTH  = 4;
    localparam logic [3:0]     POLY   = 4'h3;
    localparam logic [3:0]     SEED   = 4'h1;
    localparam logic [3:0]     GOLDEN = 4'h3;
    localparam int unsigned    CW     = 4;
    localparam logic [3:0]     NVEC   = 4'd4;

    typedef struct packed {
        logic [3:0] sig;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        logic       pass;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       running = 1'b0;
    logic       bist_end = 1'b0;
    logic       resp_valid = 1'b0;
    logic [3:0] resp_in = 4'h0;
    logic [3:0] signature;
    logic [3:0] vec_cnt;
    logic       busy;
    logic       done;
    logic       pass;

    int n_checks = 0;
    int n_fail = 0;

    out_t exp_q[$];
    out_t obs_q[$];

    // reference model state: 0=idle 1=compact 2=done
    int         m_st = 0;
    logic [3:0] m_sig = SEED;
    logic [3:0] m_cnt = 4'h0;
    logic       m_pass = 1'b0;

    bist_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED),
        .GOLDEN(GOLDEN),
        .CW    (CW),
        .NVEC  (NVEC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .running   (running),
        .bist_end  (bist_end),
        .resp_valid(resp_valid),
        .resp_in   (resp_in),
        .signature (signature),
        .vec_cnt   (vec_cnt),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic rst, input logic run, input logic be,
                                  input logic vld, input logic [3:0] d);
        if (!rst) begin
            m_st = 0; m_sig = SEED; m_cnt = 4'h0; m_pass = 1'b0;
        end else begin
            case (m_st)
                0: if (run) begin m_sig = SEED; m_cnt = 4'h0; m_st = 1; end
                1: begin
                    if (be) begin
                        m_pass = (m_sig == GOLDEN) && (m_cnt == NVEC);
                        m_st = 2;
                    end else if (!run) begin
                        m_st = 0;
                    end else if (vld) begin
                        m_sig = {m_sig[2:0], 1'b0} ^ (m_sig[3] ? POLY : 4'h0) ^ d;
                        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
                    end
                end
                default: if (!be) begin m_st = 0; m_pass = 1'b0; end
            endcase
        end
    endfunction

    // Drive one cycle (called at posedge+1), predict, then capture outputs at next posedge+1.
    task automatic step(input logic rst, input logic run, input logic be, input logic vld,
                        input logic [3:0] d);
        out_t e;
        reset = rst; running = run; bist_end = be; resp_valid = vld; resp_in = d;
        model(rst, run, be, vld, d);
        e.sig = m_sig; e.cnt = m_cnt; e.busy = (m_st == 1); e.done = (m_st == 2);
        e.pass = m_pass;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back({signature, vec_cnt, busy, done, pass});
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) step(1'b0, i[0], 1'b0, 1'b0, 4'h0);
        n_checks++;
        if ({signature, vec_cnt, busy, done, pass} !== {4'h1, 4'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_values: got sig=%h cnt=%0d bdp=%b%b%b, expected sig=1 cnt=0 bdp=000",
                     signature, vec_cnt, busy, done, pass);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_sb: got %h/%0d/%b%b%b expected %h/%0d/%b%b%b",
                         o.sig, o.cnt, o.busy, o.done, o.pass, e.sig, e.cnt, e.busy, e.done, e.pass);
            end
        end
    endtask

    task automatic run_session(input int nvec, input logic [3:0] last, input logic fault);
        logic [3:0] d;
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h7);
        for (int i = 0; i < nvec; i++) begin
            d = (fault && i == nvec - 1) ? last : 4'h0;
            step(1'b1, 1'b1, 1'b0, 1'b1, d);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    endtask

    task automatic test_golden();
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        n_checks++;
        if (busy !== 1'b1 || signature !== 4'h1) begin
            n_fail++;
            $display("FAIL golden_start: got busy=%b sig=%h, expected busy=1 sig=1", busy, signature);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        n_checks++;
        if ({signature, vec_cnt, busy, done, pass} !== {4'h3, 4'h4, 3'b011}) begin
            n_fail++;
            $display("FAIL golden_verdict: got sig=%h cnt=%0d bdp=%b%b%b, expected sig=3 cnt=4 bdp=011",
                     signature, vec_cnt, busy, done, pass);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'h5);  // running ignored in DONE
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        n_checks++;
        if ({done, pass} !== 2'b00 || signature !== 4'h3) begin
            n_fail++;
            $display("FAIL golden_exit: got done=%b pass=%b sig=%h, expected 0 0 3", done, pass, signature);
        end
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL golden_sb: got %h/%0d/%b%b%b expected %h/%0d/%b%b%b",
                         o.sig, o.cnt, o.busy, o.done, o.pass, e.sig, e.cnt, e.busy, e.done, e.pass);
            end
        end
    endtask

    task automatic test_fault_and_count();
        run_session(4, 4'h1, 1'b1);
        n_checks++;
        if ({signature, done, pass} !== {4'h2, 2'b10}) begin
            n_fail++;
            $display("FAIL fault_inject: got sig=%h done=%b pass=%b, expected sig=2 done=1 pass=0",
                     signature, done, pass);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        // five zero vectors with idle gaps
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
            step(1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        n_checks++;
        if ({signature, vec_cnt, done, pass} !== {4'h6, 4'h5, 2'b10}) begin
            n_fail++;
            $display("FAIL count_mismatch: got sig=%h cnt=%0d done=%b pass=%b, expected 6 5 1 0",
                     signature, vec_cnt, done, pass);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fault_sb: got %h/%0d/%b%b%b expected %h/%0d/%b%b%b",
                         o.sig, o.cnt, o.busy, o.done, o.pass, e.sig, e.cnt, e.busy, e.done, e.pass);
            end
        end
    endtask

    task automatic test_abort();
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'h9);
        n_checks++;
        if ({signature, vec_cnt, busy, done, pass} !== {4'h4, 4'h2, 3'b000}) begin
            n_fail++;
            $display("FAIL abort: got sig=%h cnt=%0d bdp=%b%b%b, expected sig=4 cnt=2 bdp=000",
                     signature, vec_cnt, busy, done, pass);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        n_checks++;
        if ({signature, vec_cnt, busy} !== {4'h1, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_restart: got sig=%h cnt=%0d busy=%b, expected 1 0 1",
                     signature, vec_cnt, busy);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_sb: got %h/%0d/%b%b%b expected %h/%0d/%b%b%b",
                         o.sig, o.cnt, o.busy, o.done, o.pass, e.sig, e.cnt, e.busy, e.done, e.pass);
            end
        end
    endtask

    task automatic test_back_to_back();
        // running and bist_end together in IDLE: zero-vector session
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        n_checks++;
        if ({vec_cnt, busy, done, pass} !== {4'h0, 3'b010}) begin
            n_fail++;
            $display("FAIL zero_vec: got cnt=%0d bdp=%b%b%b, expected cnt=0 bdp=010",
                     vec_cnt, busy, done, pass);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        // bist_end with resp_valid: last word dropped
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'hA);
        n_checks++;
        if ({signature, vec_cnt, pass} !== {4'h3, 4'h4, 1'b1}) begin
            n_fail++;
            $display("FAIL end_with_valid: got sig=%h cnt=%0d pass=%b, expected 3 4 1",
                     signature, vec_cnt, pass);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        // saturation with random responses
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
        n_checks++;
        if (vec_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d, expected 15", vec_cnt);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_sb: got %h/%0d/%b%b%b expected %h/%0d/%b%b%b",
                         o.sig, o.cnt, o.busy, o.done, o.pass, e.sig, e.cnt, e.busy, e.done, e.pass);
            end
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h6);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        reset = 1'b0;
        #2;
        model(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        n_checks++;
        if ({signature, vec_cnt, busy, done, pass} !== {4'h1, 4'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset: got sig=%h cnt=%0d bdp=%b%b%b, expected sig=1 cnt=0 bdp=000",
                     signature, vec_cnt, busy, done, pass);
        end
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midreset_sb: got %h/%0d/%b%b%b expected %h/%0d/%b%b%b",
                         o.sig, o.cnt, o.busy, o.done, o.pass, e.sig, e.cnt, e.busy, e.done, e.pass);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_golden();
        test_fault_and_count();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
